window_line_buffer: RTL and testbench



---
 rtl/window_buffer_pkg.sv | 13 +
 rtl/flex_counter.sv | 22 ++
 rtl/window_line_buffer.sv | 127 ++++++++++++
 tb/tb_window_line_buffer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/window_buffer_pkg.sv
// Shared types and helpers for the sliding-window line buffer.
package window_buffer_pkg;

  typedef enum logic [1:0] {IDLE, FILL, SLIDE, REFILL} state_t;

  localparam int DEF_PIXEL_W = 24;
  typedef logic [DEF_PIXEL_W-1:0] pixel_t;

  function automatic int win_bits(input int lines, input int pixel_w);
    return lines * lines * pixel_w;
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear and programmable wrap value.
module flex_counter #(
  parameter int NUM_BITS = 4
)(
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic                count_enable,
  input  logic [NUM_BITS-1:0] rollover_val,
  output logic [NUM_BITS-1:0] count_out
);

  always_ff @(posedge clk) begin
    if (!n_rst)
      count_out <= '0;
    else if (clear)
      count_out <= '0;
    else if (count_enable)
      count_out <= (count_out == rollover_val) ? '0 : count_out + NUM_BITS'(1);
  end

endmodule

// File: rtl/window_line_buffer.sv
// LINES-row pixel store fed one beat at a time; slides a LINESxLINES window
// across each row position and refills one row per position down the strip.
module window_line_buffer
  import window_buffer_pkg::*;
#(
  parameter int PIXEL_W = 24,
  parameter int BUS_W   = 32,
  parameter int LINES   = 3,
  parameter int CHUNK   = 8,
  parameter int ROW_W   = 10
)(
  input  logic                                clk,
  input  logic                                n_rst,
  input  logic                                load_start,
  input  logic [ROW_W-1:0]                    num_rows,
  input  logic [BUS_W-1:0]                    master_readdata,
  input  logic                                master_readdatavalid,
  input  logic                                window_ready,
  output logic                                window_valid,
  output logic [win_bits(LINES,PIXEL_W)-1:0]  window_data,
  output logic                                need_data,
  output logic                                chunk_done,
  output logic                                frame_done,
  output logic                                overrun
);

  localparam int DEPTH    = LINES * CHUNK;
  localparam int BEAT_W   = $clog2(DEPTH + 1);
  localparam int COL_W    = $clog2(CHUNK);
  localparam int LAST_COL = CHUNK - LINES;
  localparam logic [ROW_W:0] LINES_R = (ROW_W+1)'(LINES);
  localparam logic [ROW_W:0] ONE_R   = (ROW_W+1)'(1);

  state_t state, state_n;

  // chain[r*CHUNK + k] holds row[r][k]; index 0 is the oldest pixel
  logic [DEPTH-1:0][PIXEL_W-1:0] chain;

  logic [BEAT_W-1:0] beat_cnt, beat_roll;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  rowpos, rows_q;
  logic              accept, last_beat, hs, last_hs, final_pos, start, short_start;

  generate
    if (BUS_W > PIXEL_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^master_readdata[BUS_W-1:PIXEL_W];
    end
  endgenerate

  assign need_data    = (state == FILL) || (state == REFILL);
  assign window_valid = (state == SLIDE);
  assign accept       = master_readdatavalid && need_data;
  assign beat_roll    = (state == FILL) ? BEAT_W'(DEPTH - 1) : BEAT_W'(CHUNK - 1);
  assign last_beat    = accept && (beat_cnt == beat_roll);
  assign hs           = window_valid && window_ready;
  assign last_hs      = hs && (col == COL_W'(LAST_COL));
  assign start        = (state == IDLE) && load_start;
  assign short_start  = start && ({1'b0, num_rows} < LINES_R);
  // rowpos is compared before its increment: last position is rows-LINES
  assign final_pos    = ({1'b0, rowpos} + ONE_R) == ({1'b0, rows_q} - LINES_R + ONE_R);

  flex_counter #(.NUM_BITS(BEAT_W)) u_beat_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (start || last_beat),
    .count_enable (accept),
    .rollover_val (beat_roll),
    .count_out    (beat_cnt)
  );

  flex_counter #(.NUM_BITS(COL_W)) u_col_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (start || last_hs),
    .count_enable (hs),
    .rollover_val (COL_W'(LAST_COL)),
    .count_out    (col)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start && !short_start) state_n = FILL;
      FILL:    if (last_beat) state_n = SLIDE;
      SLIDE:   if (last_hs) state_n = final_pos ? IDLE : REFILL;
      REFILL:  if (last_beat) state_n = SLIDE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      chain      <= '0;
      rowpos     <= '0;
      rows_q     <= '0;
      chunk_done <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      chunk_done <= last_hs;
      frame_done <= short_start || (last_hs && final_pos);
      overrun    <= master_readdatavalid && !need_data;
      if (accept)
        chain <= {master_readdata[PIXEL_W-1:0], chain[DEPTH-1:1]};
      if (start) begin
        rows_q <= num_rows;
        rowpos <= '0;
      end else if (last_hs) begin
        rowpos <= rowpos + ROW_W'(1);
      end
    end
  end

  always_comb begin
    window_data = '0;
    for (int r = 0; r < LINES; r++)
      for (int j = 0; j < LINES; j++)
        window_data[(r*LINES+j)*PIXEL_W +: PIXEL_W] = chain[r*CHUNK + j + int'(col)];
  end

endmodule

// File: tb/tb_window_line_buffer.sv
// Directed bench for window_line_buffer: fill, slide, refill, backpressure, overrun, reset.
module tb_window_line_buffer;

  localparam int PW = 24;
  localparam int L  = 3;
  localparam int CH = 8;
  localparam int WB = L * L * PW;

  logic          clk, n_rst, load_start, rdv, window_ready;
  logic [9:0]    num_rows;
  logic [31:0]   rd;
  logic          window_valid, need_data, chunk_done, frame_done, overrun;
  logic [WB-1:0] window_data;

  int checks = 0;
  int errors = 0;

  window_line_buffer #(
    .PIXEL_W(PW), .BUS_W(32), .LINES(L), .CHUNK(CH), .ROW_W(10)
  ) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .load_start           (load_start),
    .num_rows             (num_rows),
    .master_readdata      (rd),
    .master_readdatavalid (rdv),
    .window_ready         (window_ready),
    .window_valid         (window_valid),
    .window_data          (window_data),
    .need_data            (need_data),
    .chunk_done           (chunk_done),
    .frame_done           (frame_done),
    .overrun              (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WB-1:0] ew(input int a, input int b, input int c);
    int base[3];
    logic [WB-1:0] w;
    base = '{a, b, c};
    w = '0;
    for (int r = 0; r < L; r++)
      for (int j = 0; j < L; j++)
        w[(r*L+j)*PW +: PW] = PW'(base[r] + j);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic start(input int n);
    load_start = 1'b1;
    num_rows   = 10'(n);
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // upper bus bits carry junk that must be ignored
  task automatic beat(input int v, input int gap);
    rd  = {8'hA5, 24'(v)};
    rdv = 1'b1;
    @(negedge clk);
    rdv = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic drain(input int b0, input int b1, input int b2,
                       input logic exp_frame, input logic exp_need);
    for (int c = 0; c <= CH - L; c++) begin
      chk("win_valid", window_valid, 1);
      chk($sformatf("window_c%0d", c), window_data, ew(b0 + c, b1 + c, b2 + c));
      chk("chunk_early", chunk_done, 0);
      window_ready = 1'b1;
      @(negedge clk);
    end
    window_ready = 1'b0;
    chk("chunk_done", chunk_done, 1);
    chk("frame_done", frame_done, exp_frame);
    chk("valid_drop", window_valid, 0);
    chk("need_after_pos", need_data, exp_need);
    @(negedge clk);
    chk("chunk_pulse", chunk_done, 0);
    chk("frame_pulse", frame_done, 0);
  endtask

  task automatic single_pos();
    start(3);
    chk("need_fill", need_data, 1);
    chk("valid_fill", window_valid, 0);
    for (int i = 1; i <= 23; i++) beat(i, 0);
    chk("need_before_last", need_data, 1);
    beat(24, 0);
    chk("need_fell", need_data, 0);
    drain(1, 9, 17, 1'b1, 1'b0);
  endtask

  initial begin
    int exp_c, held, t;
    n_rst = 1'b0; load_start = 1'b0; num_rows = '0; rd = '0; rdv = 1'b0; window_ready = 1'b0;

    // reset with random inputs
    for (int k = 0; k < 3; k++) begin
      load_start   = 1'($urandom_range(0, 1));
      num_rows     = 10'($urandom);
      rd           = $urandom;
      rdv          = 1'($urandom_range(0, 1));
      window_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rst_valid", window_valid, 0);
      chk("rst_data", window_data, 0);
      chk("rst_need", need_data, 0);
      chk("rst_chunk", chunk_done, 0);
      chk("rst_frame", frame_done, 0);
      chk("rst_overrun", overrun, 0);
    end
    load_start = 1'b0; rdv = 1'b0; window_ready = 1'b0;
    n_rst = 1'b1;
    @(negedge clk);

    single_pos();

    // two row positions with a refill
    start(4);
    for (int i = 1; i <= 24; i++) beat(i, 0);
    drain(1, 9, 17, 1'b0, 1'b1);
    for (int i = 25; i <= 32; i++) beat(i, 0);
    chk("refill_need_fell", need_data, 0);
    drain(9, 17, 25, 1'b1, 1'b0);

    // backpressure: alternating ready plus a 5-cycle hold at c=2
    start(3);
    for (int i = 1; i <= 24; i++) beat(i, 0);
    exp_c = 0; held = 0; t = 0;
    while (exp_c < 6 && t < 60) begin
      chk("bp_valid", window_valid, 1);
      chk($sformatf("bp_window_c%0d", exp_c), window_data, ew(1 + exp_c, 9 + exp_c, 17 + exp_c));
      chk("bp_chunk_early", chunk_done, 0);
      if (exp_c == 2 && held < 5) begin
        window_ready = 1'b0;
        held++;
      end else begin
        window_ready = (t % 2 == 0);
      end
      if (window_ready) exp_c++;
      t++;
      @(negedge clk);
    end
    window_ready = 1'b0;
    chk("bp_window_count", exp_c, 6);
    chk("bp_chunk", chunk_done, 1);
    chk("bp_frame", frame_done, 1);
    chk("bp_valid_drop", window_valid, 0);
    @(negedge clk);

    // gapped beats, then a stray beat during SLIDE
    start(3);
    for (int i = 1; i <= 24; i++) beat(i, (i < 24) ? i % 4 : 0);
    beat(99, 0);
    chk("ovr_slide", overrun, 1);
    chk("ovr_window", window_data, ew(1, 9, 17));
    chk("ovr_valid", window_valid, 1);
    @(negedge clk);
    chk("ovr_pulse", overrun, 0);
    drain(1, 9, 17, 1'b1, 1'b0);
    beat(77, 0);
    chk("ovr_idle", overrun, 1);
    chk("ovr_idle_need", need_data, 0);

    // too few rows: frame_done only
    start(2);
    chk("short_frame", frame_done, 1);
    chk("short_chunk", chunk_done, 0);
    chk("short_need", need_data, 0);
    chk("short_overrun", overrun, 0);
    @(negedge clk);
    chk("short_frame_pulse", frame_done, 0);
    chk("short_valid", window_valid, 0);

    // reset partway through a fill, then a clean strip
    start(3);
    for (int i = 1; i <= 10; i++) beat(i, 0);
    n_rst = 1'b0;
    @(negedge clk);
    chk("midrst_need", need_data, 0);
    chk("midrst_data", window_data, 0);
    chk("midrst_valid", window_valid, 0);
    n_rst = 1'b1;
    @(negedge clk);
    single_pos();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
